mem_stage: RTL

Memory-access pipeline stage between the execute stage and the writeback stage of the 5-stage LoongArch-subset CPU.
- Registers the execute-to-memory payload and consumes the synchronous data-SRAM read data addressed in the previous cycle.
- Performs load byte/half extraction with sign or zero extension.
- Selects the final writeback value from load, multiplier, divider or ALU.
- Exports a forwarding/hazard bundle to decode and a payload bus to writeback, using the valid/allowin handshake.

---
 rtl/mem_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute payload, extracts load data, picks the writeback value.
// Optional MEM_HOLD_RDATA_EN: holds the SRAM read word across writeback stalls.
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  output logic         mem_allowin,
  input  logic         ex_to_mem_valid,
  input  logic [109:0] ex_to_mem_bus,
  input  logic         wb_allowin,
  output logic         mem_to_wb_valid,
  output logic [69:0]  mem_to_wb_bus,
  input  logic [31:0]  data_sram_rdata,
  input  logic [63:0]  mul_result,
  output logic [37:0]  mem_rf_zip
);

  // Handshake: a payload moves on an edge where the sender's valid and the receiver's allowin are both 1.
  // This stage never stalls internally, so it can accept whenever it is empty or writeback drains it.
  logic         mem_valid;
  logic [109:0] payload;

  assign mem_allowin     = ~mem_valid | wb_allowin;
  assign mem_to_wb_valid = mem_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid <= ex_to_mem_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      payload <= '0;
    end else if (ex_to_mem_valid && mem_allowin) begin
      payload <= ex_to_mem_bus;
    end
  end

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
  logic        res_from_mul, mul_h, res_from_div;
  logic [31:0] div_result;

  assign {rf_we, rf_waddr, pc, alu_result, ld_b, ld_bu, ld_h, ld_hu, ld_w,
          res_from_mul, mul_h, res_from_div, div_result} = payload;

  logic [31:0] rdata_eff;

`ifdef MEM_HOLD_RDATA_EN
  logic [31:0] hold;
  logic        hold_valid;

  // Capture the word seen on the first stalled cycle; released once writeback accepts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (wb_allowin) begin
      hold_valid <= 1'b0;
    end else if (mem_valid && !hold_valid) begin
      hold       <= data_sram_rdata;
      hold_valid <= 1'b1;
    end
  end

  assign rdata_eff = hold_valid ? hold : data_sram_rdata;
`else
  assign rdata_eff = data_sram_rdata;
`endif

  logic [1:0]  off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;
  logic        ld_any;
  logic [31:0] final_result;

  assign off    = alu_result[1:0];
  assign ld_any = ld_b | ld_bu | ld_h | ld_hu | ld_w;

  always_comb begin
    byte_sel = rdata_eff[7:0];
    case (off)
      2'd0: byte_sel = rdata_eff[7:0];
      2'd1: byte_sel = rdata_eff[15:8];
      2'd2: byte_sel = rdata_eff[23:16];
      2'd3: byte_sel = rdata_eff[31:24];
      default: byte_sel = rdata_eff[7:0];
    endcase
  end

  // Halfword picks by off[1] only; misaligned halves are not trapped here.
  assign half_sel = off[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  always_comb begin
    load_value = rdata_eff;
    if (ld_b) begin
      load_value = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_bu) begin
      load_value = {24'd0, byte_sel};
    end else if (ld_h) begin
      load_value = {{16{half_sel[15]}}, half_sel};
    end else if (ld_hu) begin
      load_value = {16'd0, half_sel};
    end
  end

  always_comb begin
    final_result = alu_result;
    if (ld_any) begin
      final_result = load_value;
    end else if (res_from_mul) begin
      final_result = mul_h ? mul_result[63:32] : mul_result[31:0];
    end else if (res_from_div) begin
      final_result = div_result;
    end
  end

  // Writeback applies its own valid to rf_we; decode's forwarding view needs it gated here.
  assign mem_to_wb_bus = {rf_we, rf_waddr, pc, final_result};
  assign mem_rf_zip    = {rf_we & mem_valid, rf_waddr, final_result};

endmodule
